// File: rtl/bsg_priority_encode_rr.sv
// rtl/bsg_priority_encode_rr.sv - registered priority encoder with optional round-robin rotation
//
// Reduces each accepted request vector to a single winner, presented as a
// one-hot vector plus its binary index, held in one output register.
// Input side is valid/ready, output side is valid/yumi.
//
// Ports:
//   clk_i      clock, all state updates on the rising edge
//   reset_i    synchronous active-high reset
//   i          request vector (width_p bits)
//   v_i        i is valid
//   ready_o    block accepts i this cycle (~v_o | yumi_i, low in reset)
//   one_hot_o  registered one-hot winner
//   addr_o     registered binary index of the winner
//   v_o        output register holds a result
//   yumi_i     consumer takes the result (only legal while v_o=1)

module bsg_priority_encode_rr #(
   parameter int width_p    = 32,
   parameter int lo_to_hi_p = 1,
   parameter int rr_p       = 1,
   localparam int lg_width_lp = (width_p > 1) ? $clog2(width_p) : 1
) (
   input  logic                   clk_i,
   input  logic                   reset_i,
   input  logic [width_p-1:0]     i,
   input  logic                   v_i,
   output logic                   ready_o,
   output logic [width_p-1:0]     one_hot_o,
   output logic [lg_width_lp-1:0] addr_o,
   output logic                   v_o,
   input  logic                   yumi_i
);

   // Pointer starts one step "behind" the first index to search, so the
   // first grant after reset favours index 0 (upward) or width_p-1 (downward).
   localparam logic [lg_width_lp-1:0] ptr_init_lp =
      (lo_to_hi_p != 0) ? lg_width_lp'(width_p - 1) : '0;

   logic [lg_width_lp-1:0] ptr_r;
   logic [width_p-1:0]     pri_mask;
   logic [width_p-1:0]     masked_req;
   logic [width_p-1:0]     search_req;
   logic [lg_width_lp-1:0] win_addr;
   logic [width_p-1:0]     win_one_hot;
   logic                   any_req;
   logic                   accept;

   assign ready_o = ~reset_i & (~v_o | yumi_i);
   assign accept  = v_i & ready_o;
   assign any_req = |i;

   // Rotation is done by splitting the search in two rather than rotating
   // the vector: bits strictly past the pointer (in search direction) are
   // tried first; only if none is set does the plain fixed-priority search
   // over the whole vector apply, which covers the wrapped part. This keeps
   // wrap modulo width_p for any width, power of two or not.
   always_comb begin
      pri_mask = '0;
      if (rr_p != 0) begin
         for (int b = 0; b < width_p; b++) begin
            if (lo_to_hi_p != 0)
               pri_mask[b] = (b > int'(ptr_r));
            else
               pri_mask[b] = (b < int'(ptr_r));
         end
      end
   end

   assign masked_req = i & pri_mask;
   assign search_req = (|masked_req) ? masked_req : i;

   // Fixed-priority pick over search_req; later loop iterations override
   // earlier ones, so the loop direction sets which end wins.
   always_comb begin
      win_addr = '0;
      if (lo_to_hi_p != 0) begin
         for (int b = width_p - 1; b >= 0; b--)
            if (search_req[b]) win_addr = lg_width_lp'(b);
      end else begin
         for (int b = 0; b < width_p; b++)
            if (search_req[b]) win_addr = lg_width_lp'(b);
      end
   end

   always_comb begin
      win_one_hot = '0;
      for (int b = 0; b < width_p; b++)
         win_one_hot[b] = any_req & (int'(win_addr) == b);
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         v_o       <= 1'b0;
         one_hot_o <= '0;
         addr_o    <= '0;
         ptr_r     <= ptr_init_lp;
      end else begin
         if (accept && any_req) begin
            // covers simultaneous retire-and-load as well
            one_hot_o <= win_one_hot;
            addr_o    <= win_addr;
            v_o       <= 1'b1;
            if (rr_p != 0) ptr_r <= win_addr;
         end else if (yumi_i) begin
            // an all-zero request is consumed without touching data or pointer
            v_o <= 1'b0;
         end
      end
   end

   a_yumi_without_valid: assert property (@(posedge clk_i) disable iff (reset_i)
      !(yumi_i && !v_o));

   a_v_i_known: assert property (@(posedge clk_i) disable iff (reset_i)
      !$isunknown(v_i));

   a_output_onehot: assert property (@(posedge clk_i) disable iff (reset_i)
      v_o |-> ($onehot(one_hot_o) && one_hot_o[addr_o]));

endmodule

// File: tb/tb_bsg_priority_encode_rr.sv
// tb/tb_bsg_priority_encode_rr.sv - randomized and directed bench for bsg_priority_encode_rr

module tb_bsg_priority_encode_rr;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // four configurations side by side: 32/up/rr, 32/down/fixed, 5/down/rr, 1/up/rr
   int wid  [4] = '{32, 32, 5, 1};
   int lo   [4] = '{1, 0, 0, 1};
   int rr   [4] = '{1, 0, 1, 1};

   logic [3:0][31:0] req;
   logic [3:0]       vin, yumi, rdy, vout;

   logic [31:0] oh0, oh1;
   logic [4:0]  oh2;
   logic        oh3;
   logic [4:0]  ad0, ad1;
   logic [2:0]  ad2;
   logic        ad3;

   logic [31:0] oh_a [4];
   logic [31:0] ad_a [4];
   assign oh_a[0] = oh0;
   assign oh_a[1] = oh1;
   assign oh_a[2] = 32'(oh2);
   assign oh_a[3] = 32'(oh3);
   assign ad_a[0] = 32'(ad0);
   assign ad_a[1] = 32'(ad1);
   assign ad_a[2] = 32'(ad2);
   assign ad_a[3] = 32'(ad3);

   bsg_priority_encode_rr #(.width_p(32), .lo_to_hi_p(1), .rr_p(1)) u0 (
      .clk_i(clk), .reset_i(rst), .i(req[0]), .v_i(vin[0]), .ready_o(rdy[0]),
      .one_hot_o(oh0), .addr_o(ad0), .v_o(vout[0]), .yumi_i(yumi[0]));
   bsg_priority_encode_rr #(.width_p(32), .lo_to_hi_p(0), .rr_p(0)) u1 (
      .clk_i(clk), .reset_i(rst), .i(req[1]), .v_i(vin[1]), .ready_o(rdy[1]),
      .one_hot_o(oh1), .addr_o(ad1), .v_o(vout[1]), .yumi_i(yumi[1]));
   bsg_priority_encode_rr #(.width_p(5), .lo_to_hi_p(0), .rr_p(1)) u2 (
      .clk_i(clk), .reset_i(rst), .i(req[2][4:0]), .v_i(vin[2]), .ready_o(rdy[2]),
      .one_hot_o(oh2), .addr_o(ad2), .v_o(vout[2]), .yumi_i(yumi[2]));
   bsg_priority_encode_rr #(.width_p(1), .lo_to_hi_p(1), .rr_p(1)) u3 (
      .clk_i(clk), .reset_i(rst), .i(req[3][0:0]), .v_i(vin[3]), .ready_o(rdy[3]),
      .one_hot_o(oh3), .addr_o(ad3), .v_o(vout[3]), .yumi_i(yumi[3]));

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // reference state, per configuration
   int          m_ptr  [4];
   bit          m_v    [4];
   logic [31:0] m_oh   [4];
   int          m_addr [4];

   function automatic logic [31:0] wmask(input int w);
      logic [31:0] one = 32'd1;
      return (w >= 32) ? 32'hFFFF_FFFF : ((one << w) - 32'd1);
   endfunction

   // walk the indices in the order the rules give, starting one past the
   // pointer; fixed priority is the same walk from a constant pointer
   function automatic int ref_pick(input int k, input logic [31:0] r);
      int w = wid[k];
      int p = (rr[k] != 0) ? m_ptr[k] : ((lo[k] != 0) ? w - 1 : 0);
      int idx;
      for (int s = 1; s <= w; s++) begin
         idx = (lo[k] != 0) ? (p + s) % w : (p - s + w) % w;
         if (r[idx]) return idx;
      end
      return -1;
   endfunction

   task automatic model_reset(input int k);
      m_v[k]    = 1'b0;
      m_oh[k]   = '0;
      m_addr[k] = 0;
      m_ptr[k]  = (lo[k] != 0) ? wid[k] - 1 : 0;
   endtask

   // inputs are already driven (just after a falling edge)
   task automatic tick();
      bit          acc [4];
      logic [31:0] r;
      int          idx;
      #1;
      for (int k = 0; k < 4; k++) begin
         acc[k] = vin[k] && !rst && (!m_v[k] || yumi[k]);
         check($sformatf("ready%0d", k), 32'(rdy[k]), 32'(!rst && (!m_v[k] || yumi[k])));
      end
      @(posedge clk);
      #1;
      for (int k = 0; k < 4; k++) begin
         r = req[k] & wmask(wid[k]);
         if (rst) model_reset(k);
         else if (acc[k] && r != 0) begin
            idx       = ref_pick(k, r);
            m_addr[k] = idx;
            m_oh[k]   = 32'd1 << idx;
            m_v[k]    = 1'b1;
            if (rr[k] != 0) m_ptr[k] = idx;
         end else if (yumi[k]) m_v[k] = 1'b0;
         check($sformatf("v_o%0d", k), 32'(vout[k]), 32'(m_v[k]));
         check($sformatf("addr%0d", k), ad_a[k], 32'(m_addr[k]));
         check($sformatf("one_hot%0d", k), oh_a[k], m_oh[k]);
      end
      @(negedge clk);
   endtask

   task automatic idle();
      rst  = 1'b0;
      vin  = '0;
      yumi = '0;
      req  = '0;
   endtask

   task automatic do_reset();
      idle();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   logic [31:0] rv;

   initial begin
      idle();
      @(negedge clk);
      do_reset();
      for (int k = 0; k < 4; k++) begin
         check("rst_v", 32'(vout[k]), 32'd0);
         check("rst_addr", ad_a[k], 32'd0);
         check("rst_oh", oh_a[k], 32'd0);
      end

      // all requests set: rotating grant 0,1,2 with no bubble
      for (int n = 0; n < 3; n++) begin
         idle();
         req[0] = 32'hFFFF_FFFF; vin[0] = 1'b1; yumi[0] = m_v[0];
         tick();
         check("t1_addr", ad_a[0], 32'(n));
         check("t1_v", 32'(vout[0]), 32'd1);
      end

      // wrap from pointer 31
      do_reset();
      req[0] = 32'h8000_0001; vin[0] = 1'b1;
      tick();
      check("t2_first", ad_a[0], 32'd0);
      yumi[0] = 1'b1;
      tick();
      check("t2_wrap", ad_a[0], 32'd31);
      check("t2_oh", oh_a[0], 32'h8000_0000);

      // fixed priority, highest wins
      do_reset();
      for (int n = 0; n < 3; n++) begin
         idle();
         req[1] = 32'h0000_0106; vin[1] = 1'b1; yumi[1] = m_v[1];
         tick();
         check("t3_addr", ad_a[1], 32'd8);
         check("t3_oh", oh_a[1], 32'h100);
      end

      // non power-of-two, downward rotation
      do_reset();
      req[2] = 32'h11; vin[2] = 1'b1;
      tick();
      check("t4_first", ad_a[2], 32'd4);
      yumi[2] = 1'b1;
      tick();
      check("t4_second", ad_a[2], 32'd0);

      // backpressure: frozen for 4 cycles, then retire-and-load
      idle();
      for (int n = 0; n < 4; n++) begin
         req[0] = $urandom; req[2] = $urandom; vin[0] = 1'b1; vin[2] = 1'b1;
         tick();
         check("t5_hold", ad_a[2], 32'd0);
      end
      yumi[0] = 1'b1; yumi[2] = 1'b1; req[2] = 32'h8;
      tick();
      check("t5_noblubble_v", 32'(vout[2]), 32'd1);
      check("t5_new", ad_a[2], 32'd3);

      // zero request dropped, then reset while holding a result
      do_reset();
      req[0] = 32'h0; vin[0] = 1'b1;
      tick();
      check("t6_drop_v", 32'(vout[0]), 32'd0);
      req[0] = 32'h0000_0010;
      tick();
      check("t6_ptr_kept", ad_a[0], 32'd4);
      idle();
      rst = 1'b1;
      tick();
      check("t6_rst_v", 32'(vout[0]), 32'd0);
      check("t6_rst_addr", ad_a[0], 32'd0);

      // randomized traffic on all configurations
      for (int n = 0; n < 3000; n++) begin
         rst = ($urandom_range(0, 99) == 0);
         for (int k = 0; k < 4; k++) begin
            vin[k]  = ($urandom_range(0, 3) != 0);
            yumi[k] = m_v[k] && ($urandom_range(0, 1) != 0);
            case ($urandom_range(0, 3))
               0: rv = '0;
               1: rv = $urandom;
               2: rv = 32'd1 << $urandom_range(0, 31);
               default: rv = $urandom & $urandom & $urandom;
            endcase
            req[k] = rv;
         end
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
